// File: rtl/crc_sort_loader_pkg.sv
// ----------------------------------------------------------------------------
// crc_sort_loader_pkg
// Shared definitions for the byte loader and the CRC/sort core wrapper:
// block geometry, the function codes the core understands, and the loader
// FSM state encoding.
// ----------------------------------------------------------------------------
package crc_sort_loader_pkg;

   localparam int BLK_W  = 128;
   localparam int BYTE_W = 8;
   localparam int NBYTES = BLK_W / BYTE_W;

   localparam logic [2:0] FN_CRC_GEN = 3'b011;
   localparam logic [2:0] FN_SORT    = 3'b100;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      OUT   = 3'd4
   } state_t;

   // Only these codes are forwarded to the core; anything else completes
   // locally with an all-zero result.
   function automatic logic fn_supported(input logic [2:0] fn);
      return (fn == FN_CRC_GEN) || (fn == FN_SORT);
   endfunction

endpackage

// File: rtl/crc_sort_loader.sv
// ----------------------------------------------------------------------------
// crc_sort_loader
// Collects a 16-byte packet from a valid/ready byte stream, hands the
// assembled 128-bit block to a CRC/sort core, waits (bounded by TIMEOUT) for
// the core to finish and presents the result on a valid/ready output port.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          asynchronous reset, active low
//   in_valid     upstream byte valid
//   in_ready     loader accepts a byte this cycle (IDLE/LOAD only)
//   in_data      payload byte; first byte lands in core_data[127:120]
//   in_fn        function code, sampled with the first byte only
//   core_start   one-cycle start pulse to the core
//   core_fn_sel  function select, non-zero only while the core is busy
//   core_data    assembled block, stable while the core is busy
//   core_result  core result word
//   core_done    core completion pulse (only honoured while waiting)
//   out_valid    result available
//   out_ready    consumer accepts the result
//   out_data     captured result (zero for unsupported fn or timeout)
//   out_err      result invalid because the core timed out
// ----------------------------------------------------------------------------
module crc_sort_loader
   import crc_sort_loader_pkg::*;
#(
   parameter int TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   input  logic [2:0]         in_fn,
   output logic               core_start,
   output logic [2:0]         core_fn_sel,
   output logic [BLK_W-1:0]   core_data,
   input  logic [BLK_W-1:0]   core_result,
   input  logic               core_done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [BLK_W-1:0]   out_data,
   output logic               out_err
);

   localparam int                CNT_W    = $clog2(NBYTES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES - 1);
   localparam int                TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [2:0]         fn_q, fn_d;
   logic [BLK_W-1:0]   data_q, data_d;
   logic [BLK_W-1:0]   out_data_q, out_data_d;
   logic               out_err_q, out_err_d;
   logic               xfer;

   // Gated by rst so the port reads 0 for the whole reset interval, not
   // just after the state register has been cleared.
   assign in_ready    = rst && ((state_q == IDLE) || (state_q == LOAD));
   assign xfer        = in_valid && in_ready;
   assign core_start  = (state_q == ISSUE);
   assign core_fn_sel = ((state_q == ISSUE) || (state_q == WAIT)) ? fn_q : 3'b000;
   assign core_data   = data_q;
   assign out_valid   = (state_q == OUT);
   assign out_data    = out_data_q;
   assign out_err     = out_err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      fn_d       = fn_q;
      data_d     = data_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               fn_d    = in_fn;
               // Clearing the rest of the block keeps leftovers of an
               // earlier packet off core_data during assembly.
               data_d  = {in_data, {(BLK_W - BYTE_W){1'b0}}};
               cnt_d   = CNT_W'(1);
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               // Byte k goes to bits [127-8k -: 8], i.e. MSB-first order.
               data_d[(NBYTES - 1 - int'(cnt_q)) * BYTE_W +: BYTE_W] = in_data;
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (fn_supported(fn_q)) begin
                     state_d = ISSUE;
                  end else begin
                     out_data_d = '0;
                     out_err_d  = 1'b0;
                     state_d    = OUT;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ISSUE: begin
            tmr_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done arriving in the expiry cycle still wins.
            if (core_done) begin
               out_data_d = core_result;
               out_err_d  = 1'b0;
               state_d    = OUT;
            end else if (tmr_q == TMR_LAST) begin
               out_data_d = '0;
               out_err_d  = 1'b1;
               state_d    = OUT;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tmr_q      <= '0;
         fn_q       <= 3'b000;
         data_q     <= '0;
         out_data_q <= '0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         fn_q       <= fn_d;
         data_q     <= data_d;
         out_data_q <= out_data_d;
         out_err_q  <= out_err_d;
      end
   end

endmodule

// File: tb/tb_crc_sort_loader.sv
// ----------------------------------------------------------------------------
// tb_crc_sort_loader
// Table-driven bench for crc_sort_loader with a behavioural CRC/sort core
// model, a result scoreboard and hand-written reset/stale-done sequences.
// ----------------------------------------------------------------------------
module tb_crc_sort_loader;

   localparam int TIMEOUT = 200;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic [2:0]   in_fn;
   logic         core_start;
   logic [2:0]   core_fn_sel;
   logic [127:0] core_data;
   logic [127:0] core_result = '0;
   logic         core_done = 1'b0;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_err;

   always #5 clk = ~clk;

   crc_sort_loader #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_fn       (in_fn),
      .core_start  (core_start),
      .core_fn_sel (core_fn_sel),
      .core_data   (core_data),
      .core_result (core_result),
      .core_done   (core_done),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_err     (out_err)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [2:0]   fn;
      logic [7:0]   base;
      logic [7:0]   step;
      int           lat;
      bit           mute;
      int           gap;
      int           hold;
      logic [127:0] exp_data;
      logic         exp_err;
   } vec_t;

   typedef struct {
      logic [127:0] data;
      logic         err;
   } res_t;

   res_t sb_q[$];
   vec_t vecs[10];

   // ---------------- reference models ----------------
   function automatic logic [127:0] blk_of(input logic [7:0] base, input logic [7:0] step);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) r[(15 - k) * 8 +: 8] = base + 8'(step * k);
      return r;
   endfunction

   function automatic logic [127:0] sort_model(input logic [127:0] blk);
      logic [7:0]   b [16];
      logic [7:0]   t;
      logic [127:0] r;
      for (int k = 0; k < 16; k++) b[k] = blk[(15 - k) * 8 +: 8];
      for (int i = 0; i < 15; i++)
         for (int j = 0; j < 15 - i; j++)
            if (b[j] > b[j + 1]) begin t = b[j]; b[j] = b[j + 1]; b[j + 1] = t; end
      r = '0;
      for (int i = 0; i < 16; i++) r[i * 8 +: 8] = b[i];
      return r;
   endfunction

   function automatic logic [127:0] crc_model(input logic [127:0] blk);
      logic [31:0] c;
      c = 32'h0;
      for (int k = 0; k < 16; k++) begin
         c = c ^ {blk[(15 - k) * 8 +: 8], 24'h0};
         for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return {96'h0, c};
   endfunction

   function automatic logic [127:0] core_model(input logic [2:0] fn, input logic [127:0] blk);
      if (fn == 3'b100) return sort_model(blk);
      if (fn == 3'b011) return crc_model(blk);
      return '0;
   endfunction

   // ---------------- behavioural core ----------------
   int           core_lat  = 1;
   bit           core_mute = 1'b0;
   int           pend      = 0;
   logic [127:0] pend_res  = '0;
   int           starts    = 0;

   always @(negedge clk) begin
      core_done = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            core_done   = 1'b1;
            core_result = pend_res;
         end
      end
      if (core_start) begin
         starts = starts + 1;
         if (!core_mute) begin
            pend     = core_lat;
            pend_res = core_model(core_fn_sel, core_data);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [2:0] fn);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      in_fn    = fn;
      while (!in_ready && n < 400) begin tick(); n++; end
      if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop_check();
      res_t r;
      chk("hs_out_valid", 128'(out_valid), 128'd1);
      chk("in_ready_during_out", 128'(in_ready), 128'd0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 128'(sb_q.size()), 128'd1);
      end else begin
         r = sb_q.pop_front();
         chk("out_data", out_data, r.data);
         chk("out_err", 128'(out_err), 128'(r.err));
      end
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      logic [127:0] blk, held;
      logic         held_err;
      bit           sup, hold_ok;
      int           n, s0, exp_n;
      blk       = blk_of(v.base, v.step);
      sup       = (v.fn == 3'b011) || (v.fn == 3'b100);
      core_lat  = v.lat;
      core_mute = v.mute;
      s0        = starts;
      for (int k = 0; k < 16; k++) begin
         repeat (v.gap) tick();
         send_byte(blk[(15 - k) * 8 +: 8], (k == 0) ? v.fn : ~v.fn);
      end
      sb_q.push_back('{v.exp_data, v.exp_err});
      if (sup) begin
         chk({tag, "_core_start"}, 128'(core_start), 128'd1);
         chk({tag, "_core_fn_sel"}, 128'(core_fn_sel), 128'(v.fn));
         chk({tag, "_core_data"}, core_data, blk);
      end
      n = 0;
      while (!out_valid && n < TIMEOUT + 50) begin tick(); n++; end
      if (!sup)                            exp_n = 0;
      else if (v.mute || v.lat > TIMEOUT)  exp_n = TIMEOUT + 1;
      else                                 exp_n = v.lat + 1;
      chk({tag, "_latency"}, 128'(n), 128'(exp_n));
      chk({tag, "_starts"}, 128'(starts - s0), sup ? 128'd1 : 128'd0);
      if (v.hold > 0) begin
         held     = out_data;
         held_err = out_err;
         hold_ok  = 1'b1;
         for (int i = 0; i < v.hold; i++) begin
            tick();
            if (!out_valid || in_ready || out_data !== held || out_err !== held_err) hold_ok = 1'b0;
         end
         chk({tag, "_hold_stable"}, 128'(hold_ok), 128'd1);
      end
      out_ready = 1'b1;
      pop_check();
      tick();
      out_ready = 1'b0;
      chk({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
      chk({tag, "_out_valid_after"}, 128'(out_valid), 128'd0);
   endtask

   // ---------------- test ----------------
   initial begin : main
      vec_t va, vb;
      bit   stale_ok;
      int   s0;
      logic [127:0] blk;

      vecs[0] = '{3'b100, 8'h00, 8'h01, 3,   1'b0, 0, 0, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0};
      vecs[1] = '{3'b011, 8'h00, 8'h00, 5,   1'b0, 0, 0, 128'd0, 1'b0};
      vecs[2] = '{3'b000, 8'hA5, 8'h07, 1,   1'b0, 0, 0, 128'd0, 1'b0};
      vecs[3] = '{3'b100, 8'hF0, 8'h3B, 1,   1'b0, 2, 0, sort_model(blk_of(8'hF0, 8'h3B)), 1'b0};
      vecs[4] = '{3'b011, 8'h12, 8'h11, 7,   1'b0, 0, 0, crc_model(blk_of(8'h12, 8'h11)), 1'b0};
      vecs[5] = '{3'b111, 8'h3C, 8'h05, 1,   1'b0, 1, 0, 128'd0, 1'b0};
      vecs[6] = '{3'b100, 8'h90, 8'h0D, 1,   1'b1, 0, 0, 128'd0, 1'b1};
      vecs[7] = '{3'b011, 8'h6E, 8'h2B, 4,   1'b0, 0, 10, crc_model(blk_of(8'h6E, 8'h2B)), 1'b0};
      vecs[8] = '{3'b011, 8'hC1, 8'h17, 200, 1'b0, 0, 0, crc_model(blk_of(8'hC1, 8'h17)), 1'b0};
      vecs[9] = '{3'b100, 8'h44, 8'h61, 201, 1'b0, 0, 0, 128'd0, 1'b1};
      va      = '{3'b100, 8'h77, 8'h29, 2,   1'b0, 0, 0, sort_model(blk_of(8'h77, 8'h29)), 1'b0};
      vb      = '{3'b011, 8'hE3, 8'h35, 3,   1'b0, 0, 0, crc_model(blk_of(8'hE3, 8'h35)), 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_fn     = 3'b000;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_core_start", 128'(core_start), 128'd0);
      chk("rst_core_fn_sel", 128'(core_fn_sel), 128'd0);
      chk("rst_core_data", core_data, 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_err", 128'(out_err), 128'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      chk("idle_in_ready", 128'(in_ready), 128'd1);

      for (int i = 0; i < 10; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

      // Reset in the middle of loading: partial packet must be dropped.
      core_lat  = 2;
      core_mute = 1'b0;
      for (int k = 0; k < 7; k++) send_byte(8'h80 + 8'(k), 3'b100);
      rst = 1'b0;
      #1;
      chk("midload_rst_in_ready", 128'(in_ready), 128'd0);
      chk("midload_rst_core_data", core_data, 128'd0);
      chk("midload_rst_out_valid", 128'(out_valid), 128'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("midload_idle", 128'(in_ready), 128'd1);
      apply_vec("after_load_rst", va);

      // Reset while waiting on the core; its late done must be ignored.
      core_lat  = 40;
      core_mute = 1'b0;
      s0        = starts;
      blk       = blk_of(8'h5A, 8'h13);
      for (int k = 0; k < 16; k++) send_byte(blk[(15 - k) * 8 +: 8], 3'b011);
      repeat (10) tick();
      chk("wait_fn_sel", 128'(core_fn_sel), 128'd3);
      rst = 1'b0;
      #1;
      chk("midwait_rst_fn_sel", 128'(core_fn_sel), 128'd0);
      chk("midwait_rst_core_start", 128'(core_start), 128'd0);
      chk("midwait_rst_out_valid", 128'(out_valid), 128'd0);
      tick();
      rst      = 1'b1;
      stale_ok = 1'b1;
      for (int i = 0; i < 45; i++) begin
         tick();
         if (out_valid || !in_ready) stale_ok = 1'b0;
      end
      chk("stale_done_ignored", 128'(stale_ok), 128'd1);
      chk("stale_starts", 128'(starts - s0), 128'd1);
      apply_vec("after_wait_rst", vb);

      chk("sb_drained", 128'(sb_q.size()), 128'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crc_sort_loader.md
CRC_SORT_LOADER -- requirements
Module: crc_sort_loader

Interface
REQ-001 SHALL have parameter: TIMEOUT, 200, max cycles to wait for core_done after core_start.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port: in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port: in_ready  output  1  loader accepts a byte this cycle.
REQ-006 SHALL have port: in_data  input  8  payload byte.
REQ-007 SHALL have port: in_fn  input  3  function code; sampled with the first byte of a packet only.
REQ-008 SHALL have port: core_start  output  1  one-cycle start pulse to the downstream CRC/sort core.
REQ-009 SHALL have port: core_fn_sel  output  3  function select to the core.
REQ-010 SHALL have port: core_data  output  128  assembled block to the core.
REQ-011 SHALL have port: core_result  input  128  core data_out.
REQ-012 SHALL have port: core_done  input  1  core completion pulse.
REQ-013 SHALL have port: out_valid  output  1  result available.
REQ-014 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port: out_data  output  128  captured result.
REQ-016 SHALL have port: out_err  output  1  result invalid (timeout); qualified by out_valid.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, ISSUE, WAIT, OUT.
REQ-018 SHALL drive in_ready=1 only in IDLE and LOAD; a byte transfers when in_valid and in_ready are both 1.
REQ-019 SHALL, on a byte transfer in IDLE, latch in_fn, store the byte at core_data[127:120], set the byte count to 1, and enter LOAD.
REQ-020 SHALL, in LOAD, store byte k (0-based) at core_data[127-8k -: 8], ignore in_fn, and hold on idle cycles.
REQ-021 SHALL, on the 16th byte transfer, enter ISSUE if the latched fn is 3'b011 or 3'b100; otherwise set out_data=0 and out_err=0, enter OUT, and never pulse core_start.
REQ-022 SHALL assert core_start for exactly one cycle in ISSUE, then enter WAIT and clear the timeout counter.
REQ-023 SHALL hold core_fn_sel and core_data stable from ISSUE until leaving WAIT; core_fn_sel SHALL be 3'b000 in all other states.
REQ-024 SHALL, in WAIT, capture core_result into out_data with out_err=0 in the cycle core_done=1, then enter OUT.
REQ-025 SHALL, if TIMEOUT cycles elapse in WAIT without core_done, set out_err=1 and out_data=0, then enter OUT; core_done in the same cycle as expiry SHALL take priority.
REQ-026 SHALL ignore core_done in every state except WAIT.
REQ-027 SHALL hold out_valid=1 and out_data/out_err stable in OUT until out_ready=1, then return to IDLE; in_ready SHALL rise the cycle after the handshake (no same-cycle overlap).
REQ-028 SHALL give latency from 16th byte to out_valid = core latency + 2 cycles for supported fns and 1 cycle for unsupported fns.

Reset
REQ-029 SHALL, on rst=0 at any time, including mid-LOAD or mid-WAIT, asynchronously enter IDLE with byte count 0, timeout counter 0, and a discarded partial packet.
REQ-030 SHALL reset outputs to: in_ready=0 while rst=0 (1 in IDLE after release), core_start=0, core_fn_sel=0, core_data=0, out_valid=0, out_data=0, out_err=0.

Structure
REQ-031 SHALL place the function codes CRC_GEN=3'b011 and SORT=3'b100, the FSM state encoding and the 128-bit block width in a shared package also used by the core wrapper.
REQ-032 SHALL be one flat module; the byte-assembly shift register SHALL be inline, not a sub-module.

Verification
REQ-033 SHALL cover: fn=100, bytes 0x00..0x0F back-to-back with a sort model -> out_data=128'h0F0E0D0C0B0A09080706050403020100, out_err=0.
REQ-034 SHALL cover: fn=011, 16 bytes of 0x00 with a CRC model -> out_data=128'd0, exactly one core_start pulse.
REQ-035 SHALL cover: fn=000, any 16 bytes -> core_start never asserted, out_valid 1 cycle after the 16th byte, out_data=0.
REQ-036 SHALL cover: stub core never asserts done -> out_valid with out_err=1 exactly TIMEOUT=200 cycles after WAIT entry.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles -> out_data stable, in_ready=0 throughout, and in_ready=1 the cycle after the handshake.
REQ-038 SHALL cover: rst=0 after 7 bytes and again during WAIT -> IDLE, a following full packet produces a correct result, and a stale core_done is ignored.
